// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: digit store, anti-ghost blanking, PWM dimming, outputs one cycle behind scan state.
// Optional per-digit blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int  NDIG      = 8,
    parameter int  SCAN_DIV  = 131072,
    parameter int  BLANK_CYC = 16,
    parameter int  PWM_BITS  = 4,
    parameter int  BLINK_DIV = 2**25,
    localparam int AW        = $clog2(NDIG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [5:0]          wr_data,
    input  logic [PWM_BITS-1:0] bright,
    input  logic [NDIG-1:0]     blink_mask,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);

    if (NDIG < 2 || NDIG > 16) begin : g_bad_ndig
        $error("seg_scan_ctrl: NDIG must be within 2..16");
    end
    if (BLANK_CYC < 1 || SCAN_DIV < 2 * BLANK_CYC) begin : g_bad_blank
        $error("seg_scan_ctrl: need BLANK_CYC >= 1 and SCAN_DIV >= 2*BLANK_CYC");
    end
    if (PWM_BITS > DW) begin : g_bad_pwm
        $error("seg_scan_ctrl: PWM_BITS wider than the scan divider");
    end

    logic [5:0]          store_q [NDIG];
    logic [DW-1:0]       div_q, div_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                frame_tick_q, frame_tick_d;
    logic [NDIG-1:0]     an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                wr_hit;
    logic                blink_off;
    logic                lit;
    logic [5:0]          cur;
    logic [PWM_BITS-1:0] pwm_cnt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Address is widened by one bit so the range test stays meaningful when NDIG is a power of two.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < (AW+1)'(NDIG));

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    logic [BW-1:0] blink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
        end else if (blink_q == BW'(BLINK_DIV - 1)) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BW'(1);
        end
    end

    assign blink_off = blink_mask[idx_q] && (blink_q >= BW'(BLINK_DIV / 2));
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask;
    assign blink_off    = 1'b0;
`endif

    always_comb begin
        div_d        = div_q + DW'(1);
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (idx_q == AW'(NDIG - 1)) begin
                idx_d        = '0;
                frame_tick_d = 1'b1;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    always_comb begin
        cur     = store_q[idx_q];
        pwm_cnt = div_q[PWM_BITS-1:0];
        // Full-scale brightness is always on; otherwise duty is bright/2^PWM_BITS within the lit window.
        lit     = (div_q >= DW'(BLANK_CYC)) && ((&bright) || (pwm_cnt < bright)) && !blink_off;
        an_d    = '1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d = cur[5] ? hex_glyph(cur[4:1]) : 7'h7F;
        dp_d  = cur[5] ? ~cur[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            for (int i = 0; i < NDIG; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            if (wr_hit) begin
                store_q[wr_addr] <= wr_data;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: main DUT with NDIG=4, plus an NDIG=5 instance for out-of-range write addresses.
module tb_seg_scan_ctrl;
    logic       clk, rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic [1:0] bright;
    logic [3:0] blink_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;

    logic       wr_en5;
    logic [2:0] wr_addr5;
    logic [5:0] wr_data5;
    logic [4:0] an5;
    logic [6:0] seg5;
    logic       dp5, ft5;

    typedef struct {
        int         at;
        bit         sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t lit[int];
    int   cnt = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic [5:0] m4 [4];
    logic       m5_d4;
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(.NDIG(4), .SCAN_DIV(8), .BLANK_CYC(2), .PWM_BITS(2), .BLINK_DIV(64)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bright(bright), .blink_mask(blink_mask),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.NDIG(5), .SCAN_DIV(8), .BLANK_CYC(2), .PWM_BITS(2), .BLINK_DIV(64)) dut5 (
        .clk(clk), .rst(rst), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .bright(bright), .blink_mask(5'b00000),
        .an(an5), .seg(seg5), .dp(dp5), .frame_tick(ft5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cnt-1 is the scan position whose registered outputs are visible in the current cycle.
    always @(posedge clk) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    function automatic void push_raw(int at, logic [3:0] a, logic [6:0] s, logic d, logic f, string tag);
        exp_t e;
        e.at = at; e.sel = 1'b0; e.an = a; e.seg = s; e.dp = d; e.ft = f; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void add_lit(int n, logic [3:0] a, logic [6:0] s, logic d, logic f, string tag);
        exp_t e;
        e.at = n + 1; e.sel = 1'b0; e.an = a; e.seg = s; e.dp = d; e.ft = f; e.tag = tag;
        lit[n] = e;
    endfunction

    function automatic void push_disp(int n);
        exp_t e;
        int d, i, i5;
        bit on;
        logic [5:0] s;
        d  = n % 8;
        i  = (n / 8) % 4;
        i5 = (n / 8) % 5;
        on = (d >= 2) && (bright == 2'b11 || (d % 4) < int'(bright));
`ifdef SEG_BLINK_EN
        if (blink_mask[i] && (n % 64) >= 32) on = 1'b0;
`endif
        s      = m4[i];
        e.at   = n + 1;
        e.sel  = 1'b0;
        e.an   = on ? ~(4'b0001 << i) : 4'hF;
        e.seg  = s[5] ? glyph[s[4:1]] : 7'h7F;
        e.dp   = s[5] ? ~s[0] : 1'b1;
        e.ft   = ((n % 32) == 31);
        e.tag  = "scan";
        sb.push_back(e);
        e.sel  = 1'b1;
        e.an   = 4'hF;
        e.seg  = (i5 == 4 && m5_d4) ? 7'h00 : 7'h7F;
        e.dp   = 1'b1;
        e.ft   = 1'b0;
        e.tag  = "ndig5_store";
        sb.push_back(e);
        if (lit.exists(n)) begin
            sb.push_back(lit[n]);
            lit.delete(n);
        end
    endfunction

    task automatic run(int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            push_disp(cnt - 1);
        end
    endtask

    task automatic do_write(bit which, logic [2:0] a, logic [5:0] d);
        if (which) begin
            wr_en5 = 1'b1; wr_addr5 = a; wr_data5 = d;
        end else begin
            wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d;
        end
        @(posedge clk); #1;
        push_disp(cnt - 1);
        wr_en  = 1'b0;
        wr_en5 = 1'b0;
        if (!which)          m4[a[1:0]] = d;
        else if (a == 3'd4)  m5_d4 = d[5];
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cnt) begin
            e = sb.pop_front();
            compared++;
            if (e.at != cnt) begin
                mismatched++;
                $display("FAIL %s: expectation for count %0d not checked in time (count now %0d)", e.tag, e.at, cnt);
            end else if (e.sel) begin
                if ({seg5, dp5} !== {e.seg, e.dp}) begin
                    mismatched++;
                    $display("FAIL %s @%0d: seg/dp got %h/%b expected %h/%b", e.tag, cnt, seg5, dp5, e.seg, e.dp);
                end
            end else if ({an, seg, dp, frame_tick} !== {e.an, e.seg, e.dp, e.ft}) begin
                mismatched++;
                $display("FAIL %s @%0d: an/seg/dp/ft got %b/%h/%b/%b expected %b/%h/%b/%b",
                         e.tag, cnt, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
            end
        end
        if (!rst) begin
            compared++;
            if ($countones(~an) > 1) begin
                mismatched++;
                $display("FAIL an_onehot @%0d: an got %b, at most one low bit allowed", cnt, an);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bright = 2'b11; blink_mask = 4'b0000;
        wr_en5 = 1'b0; wr_addr5 = 3'd0; wr_data5 = 6'd0;
        for (int i = 0; i < 4; i++) m4[i] = 6'd0;
        m5_d4 = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'h3F;
        repeat (3) @(posedge clk);
        #1;
        push_raw(cnt, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_state");
        wr_en = 1'b0;
        rst   = 1'b0;

        add_lit(0,  4'hF,    7'h7F, 1'b1, 1'b0, "post_reset_blank");
        add_lit(10, 4'b1101, 7'h7F, 1'b1, 1'b0, "dig1_disabled");
        add_lit(16, 4'hF,    7'h30, 1'b0, 1'b0, "dig2_in_blanking");
        add_lit(18, 4'b1011, 7'h30, 1'b0, 1'b0, "dig2_glyph3_dp");
        add_lit(23, 4'b1011, 7'h30, 1'b0, 1'b0, "dig2_slot_end");
        add_lit(31, 4'b0111, 7'h7F, 1'b1, 1'b1, "frame_tick_first");
        add_lit(32, 4'hF,    7'h7F, 1'b1, 1'b0, "frame_tick_clear");
        add_lit(50, 4'b1011, 7'h30, 1'b0, 1'b0, "dig2_frame2");
        add_lit(63, 4'b0111, 7'h7F, 1'b1, 1'b1, "frame_tick_second");
        do_write(1'b0, 3'd2, 6'b1_0011_1);
        run(64);

        bright = 2'b01;
        add_lit(66, 4'hF,    7'h7F, 1'b1, 1'b0, "b1_pwm2_off");
        add_lit(68, 4'b1110, 7'h7F, 1'b1, 1'b0, "b1_pwm0_on");
        add_lit(69, 4'hF,    7'h7F, 1'b1, 1'b0, "b1_pwm1_off");
        add_lit(84, 4'b1011, 7'h30, 1'b0, 1'b0, "b1_dig2_on");
        run(32);

        bright = 2'b10;
        add_lit(100, 4'b1110, 7'h7F, 1'b1, 1'b0, "b2_pwm0_on");
        add_lit(101, 4'b1110, 7'h7F, 1'b1, 1'b0, "b2_pwm1_on");
        add_lit(102, 4'hF,    7'h7F, 1'b1, 1'b0, "b2_pwm2_off");
        run(16);

        bright = 2'b00;
        add_lit(119, 4'hF, 7'h30, 1'b0, 1'b0, "b0_dark");
        run(16);

        bright = 2'b11;
        run(8);
        add_lit(137, 4'hF,    7'h7F, 1'b1, 1'b0, "write_not_yet");
        add_lit(138, 4'b1101, 7'h08, 1'b1, 1'b0, "write_visible_t2");
        do_write(1'b0, 3'd1, 6'b1_1010_0);
        run(40);

        do_write(1'b1, 3'd5, 6'b1_1000_0);
        run(40);
        do_write(1'b1, 3'd4, 6'b1_1000_0);
        run(40);

        blink_mask = 4'b0010;
        add_lit(266, 4'b1101, 7'h08, 1'b1, 1'b0, "blink_lit_phase");
`ifdef SEG_BLINK_EN
        add_lit(298, 4'hF,    7'h08, 1'b1, 1'b0, "blink_dark_phase");
`else
        add_lit(298, 4'b1101, 7'h08, 1'b1, 1'b0, "blink_ignored");
`endif
        run(64);
        blink_mask = 4'b0000;

        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'b1_1000_1;
        @(posedge clk); #1;
        push_raw(cnt, 4'hF, 7'h7F, 1'b1, 1'b0, "midslot_reset_blank");
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 4; i++) m4[i] = 6'd0;
        m5_d4 = 1'b0;
        add_lit(2,  4'b1110, 7'h7F, 1'b1, 1'b0, "restart_idx0_cleared");
        add_lit(10, 4'b1101, 7'h7F, 1'b1, 1'b0, "dig1_cleared");
        add_lit(18, 4'b1011, 7'h7F, 1'b1, 1'b0, "dig2_cleared");
        run(40);

        @(negedge clk);
        #1;
        if (sb.size() != 0 || lit.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL leftover_expectations: got %0d queued and %0d literal, expected 0", sb.size(), lit.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8: number of multiplexed digits, range 2..16.
REQ-002 Parameter SCAN_DIV, default 131072: clock cycles per digit slot, must be at least 2*BLANK_CYC.
REQ-003 Parameter BLANK_CYC, default 16: anti-ghost cycles at the start of each slot, must be at least 1.
REQ-004 Parameter PWM_BITS, default 4: brightness resolution.
REQ-005 Parameter BLINK_DIV, default 2**25: blink period in cycles, must be even.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port wr_en, input, 1: write strobe for the digit store.
REQ-009 Port wr_addr, input, clog2(NDIG): digit index to write.
REQ-010 Port wr_data, input, 6: [5] digit enable, [4:1] hex nibble, [0] decimal point.
REQ-011 Port bright, input, PWM_BITS: display duty level.
REQ-012 Port blink_mask, input, NDIG: per-digit blink request.
REQ-013 Port an, output, NDIG: digit anodes, active-low, at most one low.
REQ-014 Port seg, output, 7: segments, active-low, [6:0]=g..a.
REQ-015 Port dp, output, 1: decimal point, active-low.
REQ-016 Port frame_tick, output, 1: one-cycle pulse when the digit index wraps from NDIG-1 to 0.

Function
REQ-017 Digit store: NDIG x 6 flop array; a write with wr_en=1 updates entry wr_addr at the clock edge.
REQ-018 Digit store: writes with wr_addr >= NDIG are ignored.
REQ-019 Scan divider div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index idx increments, wrapping from NDIG-1 to 0.
REQ-020 frame_tick is 1 in the cycle after idx wraps to 0, and 0 otherwise.
REQ-021 Decode: nibbles 0-9 and A-F map to standard hex glyphs (b, d lowercase).
REQ-022 Decode: a digit with enable=0 drives seg=7'h7F and dp=1, but its anode still scans.
REQ-023 Pipeline: an, seg and dp are registered from idx/div_cnt of the previous cycle, so an and seg always change in the same cycle.
REQ-024 Write visibility: a write to entry idx in cycle t appears on seg/dp at t+2.
REQ-025 Blanking: an is all-ones while the registered div_cnt < BLANK_CYC.
REQ-026 PWM: pwm_cnt = div_cnt[PWM_BITS-1:0].
REQ-027 PWM: outside blanking, an[idx]=0 only when bright is all-ones or pwm_cnt < bright.
REQ-028 PWM: bright=0 keeps an all-ones.
REQ-029 A change of bright takes effect on the next cycle, with no reset of the scan.
REQ-030 Only one an bit is ever low, and no an bit is low during the cycle in which idx changes.

Reset
REQ-031 rst=1 clears div_cnt, idx, the blink counter and every digit store entry to 0.
REQ-032 rst=1 drives an all-ones, seg=7'h7F, dp=1 and frame_tick=0 on the next edge.
REQ-033 rst asserted mid-slot or mid-write overrides wr_en, so the store reads 0 after release.
REQ-034 After release, scanning starts at idx 0 with a full blanking interval.

Configuration
REQ-035 Macro SEG_BLINK_EN defined: a blink counter counts 0..BLINK_DIV-1.
REQ-036 Macro SEG_BLINK_EN defined: while the counter is >= BLINK_DIV/2, digits with blink_mask bit set are held off (an bit 1).
REQ-037 Macro SEG_BLINK_EN defined: the blink counter is free-running and unaffected by writes.
REQ-038 Macro SEG_BLINK_EN undefined: blink_mask is ignored, no blink counter is built, and the display is never blinked.

Verification (NDIG=4, SCAN_DIV=8, BLANK_CYC=2, PWM_BITS=2, BLINK_DIV=64)
REQ-039 Reset then write 6'b1_0011_1 to entry 2: when idx=2, from div_cnt 2, seg=7'b0110000 and dp=0; the other digits stay blank.
REQ-040 bright=2'b11 then 2'b01: at 2'b11, an[idx] is low for 6 of 8 slot cycles; at 2'b01, it is low only in cycles with pwm_cnt=0; bright=0 keeps an=4'hF.
REQ-041 Run 64 cycles: idx sequence is 0,1,2,3,0, frame_tick pulses exactly twice, 32 cycles apart, and an never has two low bits.
REQ-042 Write to the displayed entry at cycle t: the new glyph appears at t+2; writing wr_addr=5 changes nothing.
REQ-043 Assert rst for 1 cycle mid-slot during wr_en: outputs go blank, all entries read disabled, and scanning restarts at idx 0.
REQ-044 With SEG_BLINK_EN and blink_mask=4'b0010: digit 1 is dark for cycles 32..63 of each blink period; without the macro, digit 1 is unaffected.
